// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, bit-period helper and majority vote.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_rx_state_t;

    function automatic int bit_period(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

    function automatic logic majority3(input logic [2:0] v);
        return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Line synchroniser for the UART receiver; with UART_RX_MAJORITY_EN the sample value
// is a 2-of-3 vote over the last three synchronised cycles.
module uart_rx_sync
    import uart_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic rx_wire,
    output logic rxd_s,
    output logic smp_s
);

    logic [1:0] sync_r;

    // Two-flop synchroniser, idles high so reset never looks like a start edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= 2'b11;
        end else begin
            sync_r <= {sync_r[0], rx_wire};
        end
    end

    assign rxd_s = sync_r[1];

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] hist_r;

    // History of the two previous synchronised values for the majority vote
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_r <= 2'b11;
        end else begin
            hist_r <= {hist_r[0], rxd_s};
        end
    end

    assign smp_s = majority3({rxd_s, hist_r});
`else
    assign smp_s = rxd_s;
`endif

endmodule

// File: rtl/uart_rx_axis.sv
// UART receiver: 8N1 deserialiser delivering bytes through a one-entry AXI-Stream slot.
// Optional UART_RX_MAJORITY_EN selects majority-voted bit sampling.
module uart_rx_axis
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD_RATE  = 9600,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rx_wire,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  frame_err,
    output logic                  overrun_err
);

    localparam int BIT_PERIOD = bit_period(CLK_FREQ, BAUD_RATE);
    localparam int CNT_W      = $clog2(BIT_PERIOD);
    localparam int BIT_W      = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BIT_PERIOD / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(BIT_PERIOD - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_WIDTH - 1);

    uart_rx_state_t          state_r;
    logic [CNT_W-1:0]        baud_cnt_r;
    logic [BIT_W-1:0]        bit_cnt_r;
    logic [DATA_WIDTH-1:0]   shift_r;
    logic                    rxd_prev_r;
    logic                    rxd_s;
    logic                    smp_s;
    logic                    half_hit_s;
    logic                    full_hit_s;
    logic                    stop_done_s;
    logic                    byte_good_s;
    logic                    byte_bad_s;

    uart_rx_sync u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .rx_wire (rx_wire),
        .rxd_s   (rxd_s),
        .smp_s   (smp_s)
    );

    assign half_hit_s  = (baud_cnt_r == HALF_LAST);
    assign full_hit_s  = (baud_cnt_r == FULL_LAST);
    assign stop_done_s = (state_r == STOP) && full_hit_s;
    assign byte_good_s = stop_done_s && smp_s;
    assign byte_bad_s  = stop_done_s && !smp_s;

    // Frame FSM: start detect, mid-bit sampling, deserialisation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            baud_cnt_r <= '0;
            bit_cnt_r  <= '0;
            shift_r    <= '0;
            rxd_prev_r <= 1'b1;
        end else begin
            rxd_prev_r <= rxd_s;
            case (state_r)
                IDLE: begin
                    baud_cnt_r <= '0;
                    bit_cnt_r  <= '0;
                    if (rxd_prev_r && !rxd_s) begin
                        state_r <= START;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                START: begin
                    if (half_hit_s) begin
                        baud_cnt_r <= '0;
                        state_r    <= smp_s ? IDLE : DATA;
                    end else begin
                        baud_cnt_r <= baud_cnt_r + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (full_hit_s) begin
                        baud_cnt_r <= '0;
                        shift_r    <= {smp_s, shift_r[DATA_WIDTH-1:1]};
                        if (bit_cnt_r == BIT_LAST) begin
                            bit_cnt_r <= '0;
                            state_r   <= STOP;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + BIT_W'(1);
                        end
                    end else begin
                        baud_cnt_r <= baud_cnt_r + CNT_W'(1);
                    end
                end
                STOP: begin
                    // Leave mid stop bit so a back-to-back start edge is not missed
                    if (full_hit_s) begin
                        baud_cnt_r <= '0;
                        state_r    <= IDLE;
                    end else begin
                        baud_cnt_r <= baud_cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    baud_cnt_r <= '0;
                    bit_cnt_r  <= '0;
                end
            endcase
        end
    end

    // Output slot and error pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            frame_err     <= 1'b0;
            overrun_err   <= 1'b0;
        end else begin
            frame_err   <= byte_bad_s;
            overrun_err <= byte_good_s && m_axis_tvalid && !m_axis_tready;
            if (byte_good_s && (!m_axis_tvalid || m_axis_tready)) begin
                m_axis_tdata  <= shift_r;
                m_axis_tvalid <= 1'b1;
            end else if (m_axis_tvalid && m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end else begin
                m_axis_tvalid <= m_axis_tvalid;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_axis.sv
// Self-checking bench for uart_rx_axis: directed and random frames against a frame-level model.
module tb_uart_rx_axis;

`ifdef UART_RX_MAJORITY_EN
    localparam bit MAJ = 1'b1;
`else
    localparam bit MAJ = 1'b0;
`endif
    localparam int BP = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_wire = 1'b1;
    logic [7:0] m_axis_tdata;
    logic       m_axis_tvalid;
    logic       m_axis_tready = 1'b1;
    logic       frame_err;
    logic       overrun_err;

    uart_rx_axis #(
        .CLK_FREQ   (1_000_000),
        .BAUD_RATE  (100_000),
        .DATA_WIDTH (8)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rx_wire       (rx_wire),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .frame_err     (frame_err),
        .overrun_err   (overrun_err)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // observed side
    logic [7:0] got_q[$];
    int         fe_cnt = 0;
    int         ov_cnt = 0;
    int         rise_cyc = -1;
    int         stable_viol = 0;
    logic       prev_valid = 1'b0;
    logic       hold_prev = 1'b0;
    logic [7:0] prev_data = 8'h00;

    // reference model
    logic [7:0] exp_q[$];
    int         exp_fe = 0;
    int         exp_ov = 0;
    bit         m_full = 1'b0;
    logic [7:0] m_byte = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (m_axis_tvalid && m_axis_tready) got_q.push_back(m_axis_tdata);
            if (frame_err) fe_cnt++;
            if (overrun_err) ov_cnt++;
            if (m_axis_tvalid && !prev_valid) rise_cyc = cyc;
            if (hold_prev && (m_axis_tdata !== prev_data)) stable_viol++;
            hold_prev = m_axis_tvalid && !m_axis_tready;
            prev_data = m_axis_tdata;
        end else begin
            hold_prev = 1'b0;
        end
        prev_valid = m_axis_tvalid;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input int n);
        rx_wire = v;
        tick(n);
    endtask

    // Model: a good byte goes to the consumer if ready, into the slot if empty, else overruns
    task automatic model_frame(input logic [7:0] d, input bit stop_ok);
        if (!stop_ok) exp_fe++;
        else if (m_axis_tready) exp_q.push_back(d);
        else if (m_full) exp_ov++;
        else begin
            m_full = 1'b1;
            m_byte = d;
        end
    endtask

    task automatic set_ready(input logic r);
        m_axis_tready = r;
        if (r && m_full) begin
            exp_q.push_back(m_byte);
            m_full = 1'b0;
        end
    endtask

    // Whole frame; glitch >= 0 inverts one cycle in the middle of that data bit
    task automatic send(input logic [7:0] d, input bit stop_ok, input int glitch, input int gap);
        logic [7:0] seen;
        seen = d;
        if (glitch >= 0 && !MAJ) seen[glitch] = ~seen[glitch];
        model_frame(seen, stop_ok);
        drive(1'b0, BP);
        for (int i = 0; i < 8; i++) begin
            if (i == glitch) begin
                drive(d[i], 5);
                drive(~d[i], 1);
                drive(d[i], 4);
            end else begin
                drive(d[i], BP);
            end
        end
        drive(stop_ok ? 1'b1 : 1'b0, BP);
        drive(1'b1, gap);
    endtask

    task automatic check_beats(input string tag);
        int n;
        check({tag, "_count"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check({tag, "_data"}, got_q[i], exp_q[i]);
        check({tag, "_frame_err"}, fe_cnt, exp_fe);
        check({tag, "_overrun"}, ov_cnt, exp_ov);
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int c0;
        #1;
        check("rst_tvalid", m_axis_tvalid, 1'b0);
        check("rst_tdata", m_axis_tdata, 8'h00);
        check("rst_errs", {frame_err, overrun_err}, 2'b00);
        tick(4);
        rst_n = 1'b1;
        tick(5);

        // Single byte and latency from line fall to tvalid
        c0 = cyc;
        send(8'hA5, 1'b1, -1, 10);
        check("latency", rise_cyc - c0, 2 + 5 + 80 + 10 + 1);
        check_beats("a5");

        // Back-to-back frames into a stalled consumer
        set_ready(1'b0);
        send(8'h3C, 1'b1, -1, 0);
        send(8'hC3, 1'b1, -1, 5);
        check("ovr_tvalid", m_axis_tvalid, 1'b1);
        check("ovr_tdata", m_axis_tdata, 8'h3C);
        set_ready(1'b1);
        tick(3);
        check_beats("overrun");

        // Short start pulse is rejected
        drive(1'b0, 3);
        drive(1'b1, 30);
        check("glitch_tvalid", m_axis_tvalid, 1'b0);
        check_beats("start_glitch");

        // Bad stop bit, then a clean frame
        send(8'h55, 1'b0, -1, 10);
        check("fe_tvalid", m_axis_tvalid, 1'b0);
        send(8'h12, 1'b1, -1, 10);
        check_beats("frame_err");

        // Break condition: one framing error, nothing delivered, no restart while low
        exp_fe++;
        drive(1'b0, 200);
        drive(1'b1, 20);
        send(8'h33, 1'b1, -1, 10);
        check_beats("break");

        // Reset mid-frame with a byte parked in the slot
        set_ready(1'b0);
        send(8'h5A, 1'b1, -1, 5);
        check("park_tvalid", m_axis_tvalid, 1'b1);
        drive(1'b0, BP);
        for (int i = 0; i < 4; i++) drive(1'b1, BP);
        drive(1'b0, 3);
        rst_n = 1'b0;
        #1;
        check("mid_rst_outs", {m_axis_tvalid, m_axis_tdata, frame_err, overrun_err}, 11'h000);
        m_full = 1'b0;
        rx_wire = 1'b1;
        tick(4);
        check("mid_rst_hold", {m_axis_tvalid, m_axis_tdata, frame_err, overrun_err}, 11'h000);
        rst_n = 1'b1;
        tick(5);
        set_ready(1'b1);
        send(8'hFF, 1'b1, -1, 10);
        check_beats("reset_mid");

        // Single-cycle glitch in data bit 2
        send(8'h00, 1'b1, 2, 10);
        check_beats("bit_glitch");

        // Random frames, occasional bad stop bit
        for (int k = 0; k < 10; k++) begin
            logic [7:0] d;
            bit ok;
            d  = 8'($urandom_range(0, 255));
            ok = ($urandom_range(0, 3) != 0);
            send(d, ok, -1, ok ? int'($urandom_range(0, 12)) : 10);
        end
        tick(3);
        check_beats("random");
        check("tdata_stable", stable_viol, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
